// File: rtl/bus_pkg.sv
// Shared definitions for the core's data-side bus: UART register map,
// STATUS bit positions and the UART serializer state encoding.
package bus_pkg;

  // UART register block
  localparam logic [31:0] UART_BASE  = 32'h1000_0000;
  localparam logic [31:0] TXDATA_OFS = 32'h0000_0000;
  localparam logic [31:0] STATUS_OFS = 32'h0000_0004;

  // STATUS register bit positions
  localparam int ST_BUSY  = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_EMPTY = 2;
  localparam int ST_OVF   = 3;

  // Serializer states
  typedef enum logic [1:0] {
    SER_IDLE,
    SER_START,
    SER_DATA,
    SER_STOP
  } ser_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// UART transmitter: byte FIFO feeding an 8N1 serializer with a baud counter
// and a sticky overflow flag for pushes that find the FIFO full.
module uart_tx_fifo
  import bus_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int CLK_DIV    = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] push_byte,
  input  logic       clr_ovf,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       overflow,
  output logic       uart_tx
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLK_DIV);

  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW:0]   CNT_ONE  = (PW + 1)'(1);
  localparam logic [PW:0]   CNT_FULL = (PW + 1)'(FIFO_DEPTH);
  localparam logic [BW-1:0] BAUD_ONE = BW'(1);
  localparam logic [BW-1:0] BAUD_END = BW'(CLK_DIV - 1);

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;

  ser_state_t    state, state_nxt;
  logic [BW-1:0] baud_cnt, baud_nxt;
  logic [2:0]    bit_cnt, bit_nxt;
  logic [7:0]    shreg, sh_nxt;

  logic pop;
  logic push_ok;
  logic ovf_set;
  logic bit_end;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign busy    = (state != SER_IDLE) || !empty;
  // A push into a full FIFO still fits when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop);
  assign ovf_set = push && full && !pop;
  assign bit_end = (baud_cnt == BAUD_END);

  // FIFO storage write port
  // NOTE: storage arrays are deliberately not reset; the pointers and count
  // alone decide which entries are valid, so stale contents are harmless.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= push_byte;
  end

  // FIFO pointers, occupancy and sticky overflow
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_ok, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      // Setting wins over a simultaneous clear so no drop goes unreported.
      if (ovf_set)      overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  // Serializer state, baud/bit counters and shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= SER_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_cnt  <= bit_nxt;
      shreg    <= sh_nxt;
    end
  end

  // Serializer next-state, FIFO pop and line output
  // NOTE: every output of this block is given a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_cnt;
    bit_nxt   = bit_cnt;
    sh_nxt    = shreg;
    pop       = 1'b0;
    uart_tx   = 1'b1;
    case (state)
      SER_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          sh_nxt    = fifo_mem[rd_ptr];
          state_nxt = SER_START;
          baud_nxt  = '0;
          bit_nxt   = '0;
        end
      end
      SER_START: begin
        uart_tx = 1'b0;
        if (bit_end) begin
          state_nxt = SER_DATA;
          baud_nxt  = '0;
          bit_nxt   = '0;
        end else begin
          baud_nxt = baud_cnt + BAUD_ONE;
        end
      end
      SER_DATA: begin
        uart_tx = shreg[0];
        if (bit_end) begin
          baud_nxt = '0;
          if (bit_cnt == 3'd7) begin
            state_nxt = SER_STOP;
          end else begin
            bit_nxt = bit_cnt + 3'd1;
            sh_nxt  = {1'b0, shreg[7:1]};
          end
        end else begin
          baud_nxt = baud_cnt + BAUD_ONE;
        end
      end
      SER_STOP: begin
        if (bit_end) begin
          state_nxt = SER_IDLE;
          baud_nxt  = '0;
        end else begin
          baud_nxt = baud_cnt + BAUD_ONE;
        end
      end
      default: state_nxt = SER_IDLE;
    endcase
  end

endmodule

// File: rtl/data_bus.sv
// Data-memory side of the single-cycle core: decodes the core's data port
// into a byte-enabled RAM and the UART transmitter registers, and returns
// read data one clock after the address.
module data_bus
  import bus_pkg::*;
#(
  parameter int RAM_WORDS  = 1024,
  parameter int FIFO_DEPTH = 8,
  parameter int CLK_DIV    = 868
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wr,
  input  logic [3:0]  data_wr_en,
  output logic [31:0] data_rd,
  output logic        uart_tx
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam logic [31:0] TXDATA_ADDR = UART_BASE + TXDATA_OFS;
  localparam logic [31:0] STATUS_ADDR = UART_BASE + STATUS_OFS;

  logic [31:0]   ram [RAM_WORDS];
  logic [AW-1:0] word_idx;
  logic          ram_sel;
  logic          txdata_sel;
  logic          status_sel;
  logic          tx_push;
  logic          tx_clr_ovf;
  logic          tx_full, tx_empty, tx_busy, tx_ovf;
  logic [31:0]   status_word;
  logic [31:0]   rd_next;
  logic          unused_addr_lsbs;

  // The core keeps word alignment, so the byte offset carries no information.
  assign unused_addr_lsbs = &{1'b0, data_addr[1:0]};

  // Only the low RAM window decodes to RAM; higher aliases fall through as unmapped.
  assign word_idx   = data_addr[AW+1:2];
  assign ram_sel    = (data_addr[31:AW+2] == '0);
  assign txdata_sel = (data_addr[31:2] == TXDATA_ADDR[31:2]);
  assign status_sel = (data_addr[31:2] == STATUS_ADDR[31:2]);

  assign tx_push    = txdata_sel && data_wr_en[0];
  assign tx_clr_ovf = status_sel && data_wr_en[0] && data_wr[ST_OVF];

  uart_tx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .CLK_DIV    (CLK_DIV)
  ) u_uart (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (tx_push),
    .push_byte (data_wr[7:0]),
    .clr_ovf   (tx_clr_ovf),
    .full      (tx_full),
    .empty     (tx_empty),
    .busy      (tx_busy),
    .overflow  (tx_ovf),
    .uart_tx   (uart_tx)
  );

  // Byte-lane RAM writes
  always_ff @(posedge clk) begin
    if (ram_sel) begin
      for (int i = 0; i < 4; i++) begin
        if (data_wr_en[i]) ram[word_idx][8*i +: 8] <= data_wr[8*i +: 8];
      end
    end
  end

  // STATUS register image
  always_comb begin
    status_word           = '0;
    status_word[ST_BUSY]  = tx_busy;
    status_word[ST_FULL]  = tx_full;
    status_word[ST_EMPTY] = tx_empty;
    status_word[ST_OVF]   = tx_ovf;
  end

  // Read mux; RAM is sampled before this edge's write lands (read-before-write)
  always_comb begin
    rd_next = '0;
    if (ram_sel)         rd_next = ram[word_idx];
    else if (status_sel) rd_next = status_word;
  end

  // Registered read data, valid the cycle after the address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data_rd <= '0;
    else        data_rd <= rd_next;
  end

endmodule

// File: tb/tb_data_bus.sv
// Directed bench for data_bus with a fast UART divider.
module tb_data_bus;

  localparam int CLK_DIV = 4;
  localparam logic [31:0] TXDATA = 32'h1000_0000;
  localparam logic [31:0] STATUS = 32'h1000_0004;
  localparam logic [31:0] UNMAP  = 32'h2000_0000;

  logic        clk;
  logic        rst_n;
  logic [31:0] data_addr;
  logic [31:0] data_wr;
  logic [3:0]  data_wr_en;
  logic [31:0] data_rd;
  logic        uart_tx;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  data_bus #(
    .RAM_WORDS  (1024),
    .FIFO_DEPTH (8),
    .CLK_DIV    (CLK_DIV)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_addr  (data_addr),
    .data_wr    (data_wr),
    .data_wr_en (data_wr_en),
    .data_rd    (data_rd),
    .uart_tx    (uart_tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Present one bus cycle, return 1ns after the capturing edge with writes off.
  task automatic drive(input logic [31:0] a, input logic [31:0] w, input logic [3:0] e);
    data_addr  = a;
    data_wr    = w;
    data_wr_en = e;
    @(posedge clk);
    #1;
    data_wr_en = 4'b0000;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (data_rd !== 32'h0) begin
      errors++; $display("FAIL reset_data_rd: got %h expected %h", data_rd, 32'h0);
    end
    checks++;
    if (uart_tx !== 1'b1) begin
      errors++; $display("FAIL reset_uart_tx: got %b expected 1", uart_tx);
    end
    rst_n = 1'b1;
    drive(STATUS, 32'h0, 4'b0000);
    checks++;
    if (data_rd !== 32'h4) begin
      errors++; $display("FAIL reset_status: got %h expected %h", data_rd, 32'h4);
    end
  endtask

  task automatic test_ram_lanes;
    drive(32'h10, 32'hDEAD_BEEF, 4'b1111);
    drive(32'h10, 32'h0000_00AA, 4'b0001);
    checks++;
    if (data_rd !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL ram_full_word: got %h expected %h", data_rd, 32'hDEADBEEF);
    end
    drive(32'h10, 32'h0055_0000, 4'b0100);
    drive(32'h10, 32'h0, 4'b0000);
    checks++;
    if (data_rd !== 32'hDE55_BEAA) begin
      errors++; $display("FAIL ram_byte_lanes: got %h expected %h", data_rd, 32'hDE55BEAA);
    end
  endtask

  task automatic test_read_before_write;
    drive(32'h20, 32'h1111_1111, 4'b1111);
    drive(32'h20, 32'h2222_2222, 4'b1111);
    checks++;
    if (data_rd !== 32'h1111_1111) begin
      errors++; $display("FAIL rbw_old: got %h expected %h", data_rd, 32'h11111111);
    end
    drive(32'h20, 32'h0, 4'b0000);
    checks++;
    if (data_rd !== 32'h2222_2222) begin
      errors++; $display("FAIL rbw_new: got %h expected %h", data_rd, 32'h22222222);
    end
  endtask

  task automatic test_unmapped;
    drive(UNMAP, 32'hFFFF_FFFF, 4'b1111);
    drive(UNMAP, 32'h0, 4'b0000);
    checks++;
    if (data_rd !== 32'h0) begin
      errors++; $display("FAIL unmapped_read: got %h expected %h", data_rd, 32'h0);
    end
    drive(TXDATA, 32'h0, 4'b0000);
    checks++;
    if (data_rd !== 32'h0) begin
      errors++; $display("FAIL txdata_read: got %h expected %h", data_rd, 32'h0);
    end
    // First address past the RAM must not alias onto word 0.
    drive(32'h0, 32'h1234_5678, 4'b1111);
    drive(32'h1000, 32'hFFFF_FFFF, 4'b1111);
    drive(32'h1000, 32'h0, 4'b0000);
    checks++;
    if (data_rd !== 32'h0) begin
      errors++; $display("FAIL ram_alias_read: got %h expected %h", data_rd, 32'h0);
    end
    drive(32'h0, 32'h0, 4'b0000);
    checks++;
    if (data_rd !== 32'h1234_5678) begin
      errors++; $display("FAIL ram_alias_write: got %h expected %h", data_rd, 32'h12345678);
    end
  endtask

  task automatic test_uart_frame;
    logic [7:0] pat;
    logic       exp_tx;
    pat = 8'hA5;
    drive(TXDATA, 32'h0000_00A5, 4'b0001);
    data_addr = STATUS;
    // Cycle 0 is the pop cycle; start bit 1..4, data 5..36, stop 37..40, idle 41.
    for (int c = 0; c < 42; c++) begin
      @(negedge clk);
      if (c >= 1 && c <= 4)       exp_tx = 1'b0;
      else if (c >= 5 && c <= 36) exp_tx = pat[(c - 5) / CLK_DIV];
      else                        exp_tx = 1'b1;
      checks++;
      if (uart_tx !== exp_tx) begin
        errors++; $display("FAIL frame_bit cycle %0d: got %b expected %b", c, uart_tx, exp_tx);
      end
      if (c == 10) begin
        checks++;
        if (data_rd[0] !== 1'b1) begin
          errors++; $display("FAIL frame_busy: got %b expected 1", data_rd[0]);
        end
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (data_rd !== 32'h4) begin
      errors++; $display("FAIL frame_status_after: got %h expected %h", data_rd, 32'h4);
    end
  endtask

  // Receive n frames and compare against base+i; frames must be 41 clocks apart.
  task automatic rx_frames(input int n, input logic [7:0] base);
    int prev_start;
    prev_start = -1;
    for (int i = 0; i < n; i++) begin
      logic [7:0] b;
      bit         found;
      int         start;
      found = 1'b0;
      for (int w = 0; w < 200 && !found; w++) begin
        @(negedge clk);
        if (uart_tx === 1'b0) found = 1'b1;
      end
      checks++;
      if (!found) begin
        errors++; $display("FAIL rx_start frame %0d: got no start bit expected one", i);
        return;
      end
      start = cyc;
      if (prev_start >= 0) begin
        checks++;
        if (start - prev_start !== 41) begin
          errors++; $display("FAIL rx_spacing frame %0d: got %0d expected 41", i, start - prev_start);
        end
      end
      repeat (CLK_DIV + 1) @(negedge clk);
      for (int k = 0; k < 8; k++) begin
        b[k] = uart_tx;
        if (k < 7) repeat (CLK_DIV) @(negedge clk);
      end
      checks++;
      if (b !== 8'(base + 8'(i))) begin
        errors++; $display("FAIL rx_byte frame %0d: got %h expected %h", i, b, 8'(base + 8'(i)));
      end
      repeat (CLK_DIV) @(negedge clk);
      checks++;
      if (uart_tx !== 1'b1) begin
        errors++; $display("FAIL rx_stop frame %0d: got %b expected 1", i, uart_tx);
      end
      prev_start = start;
    end
  endtask

  task automatic test_fifo_overflow;
    bit stayed_idle;
    fork
      begin
        for (int i = 0; i < 10; i++) drive(TXDATA, 32'h30 + i, 4'b0001);
        drive(STATUS, 32'h0, 4'b0000);
        checks++;
        if (data_rd !== 32'hB) begin
          errors++; $display("FAIL ovf_status: got %h expected %h", data_rd, 32'hB);
        end
        drive(STATUS, 32'h8, 4'b0001);
        drive(STATUS, 32'h0, 4'b0000);
        checks++;
        if (data_rd !== 32'h3) begin
          errors++; $display("FAIL ovf_clear: got %h expected %h", data_rd, 32'h3);
        end
      end
      rx_frames(9, 8'h30);
    join
    stayed_idle = 1'b1;
    repeat (60) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) stayed_idle = 1'b0;
    end
    checks++;
    if (!stayed_idle) begin
      errors++; $display("FAIL ovf_dropped_byte_sent: got activity expected idle line");
    end
    checks++;
    if (data_rd !== 32'h4) begin
      errors++; $display("FAIL ovf_status_end: got %h expected %h", data_rd, 32'h4);
    end
  endtask

  task automatic test_reset_midframe;
    bit stayed_idle;
    for (int i = 0; i < 4; i++) drive(TXDATA, 32'h0 + i, 4'b0001);
    data_addr = STATUS;
    // Byte 0x00 is in its data bits here, so the line is low.
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (uart_tx !== 1'b0) begin
      errors++; $display("FAIL midframe_pre_tx: got %b expected 0", uart_tx);
    end
    checks++;
    if (data_rd !== 32'h1) begin
      errors++; $display("FAIL midframe_pre_status: got %h expected %h", data_rd, 32'h1);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (uart_tx !== 1'b1) begin
      errors++; $display("FAIL midframe_reset_tx: got %b expected 1", uart_tx);
    end
    checks++;
    if (data_rd !== 32'h0) begin
      errors++; $display("FAIL midframe_reset_rd: got %h expected %h", data_rd, 32'h0);
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (data_rd !== 32'h4) begin
      errors++; $display("FAIL midframe_release_status: got %h expected %h", data_rd, 32'h4);
    end
    stayed_idle = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) stayed_idle = 1'b0;
    end
    checks++;
    if (!stayed_idle) begin
      errors++; $display("FAIL midframe_no_frames: got activity expected idle line");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n      = 1'b0;
    data_addr  = UNMAP;
    data_wr    = 32'h0;
    data_wr_en = 4'b0000;
    test_reset();
    test_ram_lanes();
    test_read_before_write();
    test_unmapped();
    test_uart_frame();
    test_fifo_overflow();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
